program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Boot loader for the 16-bit computer. Holds the CPU in reset and accepts a
//  framed word stream over a valid/ready port. Writes each frame into
//  instruction or data memory, then releases the CPU.
//  Replaces hierarchical testbench pokes of instmem/mem with synthesisable
//  loading. Generalised in word width and both memory depths.
//  Optionally zero-fills data memory first.
// PARAMETERS
//  WORD_W      16  data/instruction word width (>= IMEM_AW+2, >= DMEM_AW+2)
//  IMEM_AW      3  instruction memory address width (depth 2**IMEM_AW)
//  DMEM_AW      3  data memory address width (depth 2**DMEM_AW)
//  CLEAR_DMEM   1  1: zero every data memory word after reset, before loading
// PORTS
//  CLK         in   1        clock, rising edge
//  RESET       in   1        synchronous, active-high reset
//  in_valid    in   1        stream word present
//  in_data     in   WORD_W   stream word
//  in_ready    out  1        loader accepts in_data this cycle
//  imem_we     out  1        instruction memory write strobe
//  imem_addr   out  IMEM_AW  instruction memory write address
//  imem_wdata  out  WORD_W   instruction memory write data
//  dmem_we     out  1        data memory write strobe
//  dmem_addr   out  DMEM_AW  data memory write address
//  dmem_wdata  out  WORD_W   data memory write data
//  cpu_reset   out  1        synchronous reset to the processor
//  done        out  1        load complete, CPU running
//  err         out  1        malformed frame, sticky
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: all we/addr/wdata = 0, in_ready=0, cpu_reset=1, done=0, err=0.
//  - RESET next state: CLEAR if CLEAR_DMEM, else HDR.
//  - Handshake: a word transfers when in_valid & in_ready. in_ready depends
//    only on state, not on in_valid.
//  - Frame: HDR word, ADDR word, then N DATA words.
//    HDR[WORD_W-1] selects the target (0=imem, 1=dmem).
//    HDR[WORD_W-2:0] = N.
//  - CLEAR: in_ready=0. Writes dmem 0..2**DMEM_AW-1 with 0, one per cycle,
//    dmem_we=1. Next state is HDR after the last address.
//  - HDR: in_ready=1. On accept:
//    N==0 -> RUN.
//    N > target depth -> ERR.
//    Otherwise latch target and N -> ADDR.
//  - ADDR: in_ready=1. On accept:
//    Any bit of in_data above the target address width set -> ERR.
//    Otherwise latch the start address -> DATA.
//  - DATA: in_ready=1. A word accepted in cycle t drives the target we=1,
//    addr, and wdata in cycle t+1 for exactly one cycle.
//    Address increments modulo target depth (wrap permitted).
//    After the Nth accept -> HDR. No-transfer cycles produce no write.
//  - RUN: in_ready=0. cpu_reset=0 and done=1 from the cycle after the N==0
//    header is accepted. Held until RESET.
//  - ERR: err=1 from the cycle after the offending accept. In ERR,
//    cpu_reset=1, in_ready=0, done=0, and no further writes occur.
//    Held until RESET.
//  - Simultaneous events: RESET overrides everything.
//  - RESET mid-frame: the frame is abandoned and words already written stay
//    in memory. The dmem clear reruns if CLEAR_DMEM.
//  - imem and dmem strobes are never high in the same cycle.
// STRUCTURE
//  - Shared package cpu_pkg holds:
//    * WORD_W default
//    * loader state encoding (CLEAR, HDR, ADDR, DATA, RUN, ERR)
//    * HDR field positions
//    * processor opcode constants (LDI, ST, LD, ADI, ADD, NOP), shared with
//      the test programs
//  - Single module with no sub-module: one FSM, one down-counter for N, one
//    address counter reused by CLEAR.
// TESTING
//  1. RESET 1 cycle, CLEAR_DMEM=1 -> dmem_we=1 for 8 cycles at addr 0..7 with
//     wdata 0; then in_ready=1, cpu_reset=1.
//  2. Stream 0x0003,0x0000,0x98C3,0x9906,0x401C,0x0000 (LDI R3,3; LDI R4,6;
//     ST R3,R4) -> imem[0..2]=0x98C3,0x9906,0x401C. Then cpu_reset=0, done=1.
//  3. Stream 0x8002,0x0007,0x1111,0x2222,0x0000 -> dmem[7]=0x1111,
//     dmem[0]=0x2222 (wrap). No imem writes.
//  4. Header 0x0009 (N=9 > depth 8) -> err=1 next cycle, in_ready=0,
//     cpu_reset=1, no writes. Further in_valid is ignored.
//  5. Header 0x0001 with address 0x0008 (bit 3 set) -> err=1 next cycle, no
//     writes, cpu_reset=1.
//  6. Frame of 3 words with in_valid gaps of 2 cycles -> exactly 3 imem
//     writes, each one cycle after its accept.
//  7. RESET after the first of 3 DATA words -> reset values next cycle, clear
//     sequence reruns. A fresh frame then loads correctly and imem[0] keeps
//     its earlier write.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit computer: word width, loader states,
// boot-header field positions and processor opcodes used by test programs.
package cpu_pkg;

    localparam int unsigned WORD_W_DEF = 16;

    typedef enum logic [2:0] {
        StClear,
        StHdr,
        StAddr,
        StData,
        StRun,
        StErr
    } loader_state_e;

    // Header word: MSB selects the target memory (1 = dmem); the rest is N.
    function automatic int unsigned hdr_tgt_bit(input int unsigned word_w);
        return word_w - 1;
    endfunction

    function automatic int unsigned hdr_n_msb(input int unsigned word_w);
        return word_w - 2;
    endfunction

    localparam int unsigned HDR_N_LSB = 0;

    // Opcodes occupy the top five bits of an instruction word.
    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_ST  = 5'h08;
    localparam logic [4:0] OP_LD  = 5'h09;
    localparam logic [4:0] OP_ADD = 5'h11;
    localparam logic [4:0] OP_ADI = 5'h12;
    localparam logic [4:0] OP_LDI = 5'h13;

endpackage

// File: rtl/program_loader_if.sv
// Boot stream input plus memory write ports and CPU control of the loader.
interface program_loader_if #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned IMEM_AW = 3,
    parameter int unsigned DMEM_AW = 3
) ();

    logic               in_valid;
    logic [WORD_W-1:0]  in_data;
    logic               in_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [WORD_W-1:0]  imem_wdata;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [WORD_W-1:0]  dmem_wdata;
    logic               cpu_reset;
    logic               done;
    logic               err;

    // Loader side: consumes the stream, drives memories and CPU control.
    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output dmem_we, dmem_addr, dmem_wdata, cpu_reset, done, err
    );

    // Host side: produces the stream, observes memory writes and status.
    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  dmem_we, dmem_addr, dmem_wdata, cpu_reset, done, err
    );

endinterface

// File: rtl/program_loader.sv
// Boot loader: optionally zero-fills dmem, then parses HDR/ADDR/DATA frames
// into imem or dmem and finally releases the CPU from reset.
module program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned IMEM_AW    = 3,
    parameter int unsigned DMEM_AW    = 3,
    parameter bit          CLEAR_DMEM = 1'b1
) (
    input logic             CLK,
    input logic             RESET,
    program_loader_if.slave bus
);

    localparam int unsigned AW      = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
    localparam int unsigned NW      = WORD_W - 1;
    localparam int unsigned TGT_BIT = hdr_tgt_bit(WORD_W);
    localparam int unsigned N_MSB   = hdr_n_msb(WORD_W);

    localparam logic [NW-1:0] IMEM_DEPTH = NW'(2 ** IMEM_AW);
    localparam logic [NW-1:0] DMEM_DEPTH = NW'(2 ** DMEM_AW);
    localparam logic [AW-1:0] CLR_LAST   = AW'(2 ** DMEM_AW - 1);

    loader_state_e      state_q, state_d;
    logic [NW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               tgt_q, tgt_d;
    logic               in_ready_q, in_ready_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0]  imem_wdata_q, imem_wdata_d;
    logic               dmem_we_q, dmem_we_d;
    logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [WORD_W-1:0]  dmem_wdata_q, dmem_wdata_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic [NW-1:0]      hdr_n;
    logic               hdr_tgt;
    logic               addr_bad;
    logic [IMEM_AW-1:0] imem_next;
    logic [DMEM_AW-1:0] dmem_next;

    assign accept    = bus.in_valid & in_ready_q;
    assign hdr_n     = bus.in_data[N_MSB:HDR_N_LSB];
    assign hdr_tgt   = bus.in_data[TGT_BIT];
    // Start address must fit the selected memory; any higher bit is malformed.
    assign addr_bad  = tgt_q ? ((bus.in_data >> DMEM_AW) != '0)
                             : ((bus.in_data >> IMEM_AW) != '0);
    assign imem_next = addr_q[IMEM_AW-1:0] + IMEM_AW'(1);
    assign dmem_next = addr_q[DMEM_AW-1:0] + DMEM_AW'(1);

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        tgt_d        = tgt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;

        unique case (state_q)
            StClear: begin
                dmem_we_d    = 1'b1;
                dmem_addr_d  = addr_q[DMEM_AW-1:0];
                dmem_wdata_d = '0;
                if (addr_q == CLR_LAST) begin
                    addr_d  = '0;
                    state_d = StHdr;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            StHdr: begin
                if (accept) begin
                    if (hdr_n == '0) begin
                        state_d = StRun;
                    end else if (hdr_n > (hdr_tgt ? DMEM_DEPTH : IMEM_DEPTH)) begin
                        state_d = StErr;
                    end else begin
                        tgt_d   = hdr_tgt;
                        cnt_d   = hdr_n;
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (accept) begin
                    if (addr_bad) begin
                        state_d = StErr;
                    end else begin
                        addr_d  = bus.in_data[AW-1:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    if (tgt_q) begin
                        dmem_we_d    = 1'b1;
                        dmem_addr_d  = addr_q[DMEM_AW-1:0];
                        dmem_wdata_d = bus.in_data;
                        addr_d       = AW'(dmem_next);
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = addr_q[IMEM_AW-1:0];
                        imem_wdata_d = bus.in_data;
                        addr_d       = AW'(imem_next);
                    end
                    cnt_d = cnt_q - NW'(1);
                    if (cnt_q == NW'(1)) begin
                        state_d = StHdr;
                    end
                end
            end
            StRun, StErr: begin
            end
            default: state_d = StErr;
        endcase

        // Status outputs follow the state being entered so they change one
        // cycle after the deciding accept.
        in_ready_d  = (state_d == StHdr) || (state_d == StAddr) || (state_d == StData);
        cpu_reset_d = (state_d != StRun);
        done_d      = (state_d == StRun);
        err_d       = (state_d == StErr);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= CLEAR_DMEM ? StClear : StHdr;
            cnt_q        <= '0;
            addr_q       <= '0;
            tgt_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            tgt_q        <= tgt_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed boot streams plus random frames, each
// compared against a frame-level model of memory contents and status.
module tb_program_loader;
    import cpu_pkg::*;

    localparam int unsigned WW   = 16;
    localparam int unsigned IAW  = 3;
    localparam int unsigned DAW  = 3;
    localparam int unsigned IDEP = 2 ** IAW;
    localparam int unsigned DDEP = 2 ** DAW;

    typedef struct {
        bit              tgt;
        int unsigned     addr;
        logic [WW-1:0]   data;
        int              tag;   // observed: cycle; expected: stream word index
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.WORD_W(WW), .IMEM_AW(IAW), .DMEM_AW(DAW)) bus ();

    program_loader #(
        .WORD_W    (WW),
        .IMEM_AW   (IAW),
        .DMEM_AW   (DAW),
        .CLEAR_DMEM(1'b1)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_cyc = -1;
    int done_cyc = -1;
    int overlap = 0;
    wr_t obs_w[$];
    wr_t exp_w[$];
    int acc_cyc[$];
    logic [WW-1:0] t_imem[IDEP];
    logic [WW-1:0] t_dmem[DDEP];
    logic [WW-1:0] m_imem[IDEP];
    logic [WW-1:0] m_dmem[DDEP];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observe transfers and memory writes; the bench memories act as imem/dmem.
    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (bus.imem_we) begin
            obs_w.push_back('{1'b0, int'(bus.imem_addr), bus.imem_wdata, cyc});
            t_imem[bus.imem_addr] = bus.imem_wdata;
        end
        if (bus.dmem_we) begin
            obs_w.push_back('{1'b1, int'(bus.dmem_addr), bus.dmem_wdata, cyc});
            t_dmem[bus.dmem_addr] = bus.dmem_wdata;
        end
        if (bus.imem_we && bus.dmem_we) overlap++;
        if (bus.err && err_cyc < 0) err_cyc = cyc;
        if (bus.done && done_cyc < 0) done_cyc = cyc;
    end

    // Frame-level reference: status 0 = still loading, 1 = run, 2 = error.
    task automatic model_run(input logic [WW-1:0] words[$], output int status,
                             output int consumed);
        int phase = 0;
        bit t = 1'b0;
        int unsigned a = 0, rem = 0, n, depth = IDEP;
        status   = 0;
        consumed = words.size();
        exp_w.delete();
        foreach (words[i]) begin
            if (phase == 0) begin
                n     = int'(words[i][WW-2:0]);
                t     = words[i][WW-1];
                depth = t ? DDEP : IDEP;
                if (n == 0) begin
                    status = 1; consumed = i + 1; return;
                end
                if (n > depth) begin
                    status = 2; consumed = i + 1; return;
                end
                rem   = n;
                phase = 1;
            end else if (phase == 1) begin
                if (int'(words[i]) >= depth) begin
                    status = 2; consumed = i + 1; return;
                end
                a     = int'(words[i]);
                phase = 2;
            end else begin
                exp_w.push_back('{t, a, words[i], i});
                if (t) m_dmem[a] = words[i];
                else   m_imem[a] = words[i];
                a   = (a + 1) % depth;
                rem = rem - 1;
                if (rem == 0) phase = 0;
            end
        end
    endtask

    // One-cycle reset, then the dmem zero-fill must run 0..DDEP-1.
    task automatic do_reset();
        int n = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_flags", {bus.in_ready, bus.cpu_reset, bus.done, bus.err,
                               bus.imem_we, bus.dmem_we}, 6'b010000);
        check_eq("rst_bus", {bus.imem_addr, bus.imem_wdata, bus.dmem_addr, bus.dmem_wdata}, '0);
        obs_w.delete();
        acc_cyc.delete();
        err_cyc  = -1;
        done_cyc = -1;
        overlap  = 0;
        for (int i = 0; i < DDEP; i++) m_dmem[i] = '0;
        while (!bus.in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("clr_timeout", n < 30, 1);
        @(posedge clk); #1;
        check_eq("clr_cnt", obs_w.size(), DDEP);
        foreach (obs_w[i]) begin
            check_eq("clr_wr", {obs_w[i].tgt, obs_w[i].addr[7:0], obs_w[i].data},
                     {1'b1, 8'(i), 16'h0});
            check_eq("clr_cyc", obs_w[i].tag - obs_w[0].tag, i);
        end
        check_eq("clr_flags", {bus.in_ready, bus.cpu_reset, bus.done, bus.err}, 4'b1100);
        obs_w.delete();
    endtask

    task automatic send_word(input logic [WW-1:0] w, input int gap);
        int n = 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("hs_timeout", n < 40, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = WW'($urandom);
    endtask

    task automatic run_and_check(input string name, input logic [WW-1:0] words[$],
                                 input int min_gap, input int max_gap, input bit junk);
        int st, cons, idx;
        model_run(words, st, cons);
        for (int i = 0; i < cons; i++) send_word(words[i], $urandom_range(max_gap, min_gap));
        if (junk) begin
            bus.in_valid = 1'b1;
            bus.in_data  = WW'($urandom);
            repeat (5) begin
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq({name, "_accepts"}, acc_cyc.size(), cons);
        check_eq({name, "_nwr"}, obs_w.size(), exp_w.size());
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
            check_eq({name, "_wr"}, {obs_w[i].tgt, obs_w[i].addr[7:0], obs_w[i].data},
                     {exp_w[i].tgt, exp_w[i].addr[7:0], exp_w[i].data});
            idx = exp_w[i].tag;
            check_eq({name, "_wr_lat"}, obs_w[i].tag,
                     (idx < acc_cyc.size()) ? acc_cyc[idx] + 1 : -1);
        end
        if (st == 0) begin
            check_eq({name, "_flags"}, {bus.in_ready, bus.cpu_reset, bus.done, bus.err}, 4'b1100);
        end else if (st == 1) begin
            check_eq({name, "_flags"}, {bus.in_ready, bus.cpu_reset, bus.done, bus.err}, 4'b0010);
            check_eq({name, "_done_cyc"}, done_cyc,
                     (cons <= acc_cyc.size()) ? acc_cyc[cons-1] + 1 : -1);
        end else begin
            check_eq({name, "_flags"}, {bus.in_ready, bus.cpu_reset, bus.done, bus.err}, 4'b0101);
            check_eq({name, "_err_cyc"}, err_cyc,
                     (cons <= acc_cyc.size()) ? acc_cyc[cons-1] + 1 : -1);
        end
        for (int i = 0; i < IDEP; i++) check_eq({name, "_imem"}, t_imem[i], m_imem[i]);
        for (int i = 0; i < DDEP; i++) check_eq({name, "_dmem"}, t_dmem[i], m_dmem[i]);
        check_eq({name, "_overlap"}, overlap, 0);
    endtask

    task automatic build_random(output logic [WW-1:0] q[$]);
        int nf, n, kind;
        q.delete();
        nf = $urandom_range(3, 1);
        for (int f = 0; f < nf; f++) begin
            n = $urandom_range(8, 1);
            q.push_back({1'($urandom_range(1, 0)), 15'(n)});
            q.push_back(WW'($urandom_range(7, 0)));
            for (int k = 0; k < n; k++) q.push_back(WW'($urandom));
        end
        kind = $urandom_range(9, 0);
        if (kind < 8) begin
            q.push_back(16'h0000);
        end else if (kind == 8) begin
            q.push_back({1'($urandom_range(1, 0)), 15'($urandom_range(200, 9))});
        end else begin
            q.push_back(16'h8001);
            q.push_back(WW'($urandom_range(16'hFFFF, 8)));
        end
    endtask

    initial begin
        logic [WW-1:0] words[$];
        for (int i = 0; i < IDEP; i++) begin
            t_imem[i] = '0;
            m_imem[i] = '0;
        end
        for (int i = 0; i < DDEP; i++) begin
            t_dmem[i] = '0;
            m_dmem[i] = '0;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(posedge clk); #1;

        do_reset();
        words = '{16'h0003, 16'h0000, {OP_LDI, 11'h0C3}, {OP_LDI, 11'h106},
                  {OP_ST, 11'h01C}, 16'h0000};
        run_and_check("prog", words, 0, 0, 1'b0);

        do_reset();
        words = '{16'h8002, 16'h0007, 16'h1111, 16'h2222, 16'h0000};
        run_and_check("dwrap", words, 0, 1, 1'b0);

        do_reset();
        words = '{16'h0009};
        run_and_check("bad_n", words, 0, 0, 1'b1);

        do_reset();
        words = '{16'h0001, 16'h0008};
        run_and_check("bad_addr", words, 0, 0, 1'b1);

        do_reset();
        words = '{16'h0003, 16'h0004, 16'hA5A5, 16'h5A5A, 16'h0F0F, 16'h0000};
        run_and_check("gaps", words, 2, 2, 1'b0);

        do_reset();
        words = '{16'h0003, 16'h0000, 16'hABCD};
        run_and_check("abort", words, 0, 0, 1'b0);
        do_reset();
        words = '{16'h0002, 16'h0001, 16'h1234, 16'h5678, 16'h0000};
        run_and_check("reload", words, 0, 1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            do_reset();
            build_random(words);
            run_and_check("rand", words, 0, 2, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
